// File: rtl/parallel_window_sr_pkg.sv
// parallel_window_sr_pkg
//   Shared definitions for the 2-D window shift register: op encodings,
//   default sizing and a helper for computing flattened bus widths.
package parallel_window_sr_pkg;

  typedef enum logic [1:0] {
    OP_SHIFT_COL = 2'b00,
    OP_SHIFT_ROW = 2'b01,
    OP_CLEAR     = 2'b10,
    OP_NOP       = 2'b11
  } op_e;

  localparam int unsigned PIXEL_WIDTH   = 8;
  localparam int unsigned DEFAULT_DEPTH = 3;
  localparam int unsigned DEFAULT_ROWS  = 3;

  // Width of a flattened bus holding n pixels of the given width.
  function automatic int unsigned pixel_bus_width(input int unsigned n,
                                                  input int unsigned width);
    return n * width;
  endfunction

endpackage

// File: rtl/parallel_window_sr_row.sv
// window_row_sr
//   One window row of DEPTH pixels, each with a valid bit. Element 0 is the
//   newest. Priority: clear > parallel load > serial shift > hold.
// Ports:
//   clock, reset     rising-edge clock, async active-low reset
//   shift_en         shift shift_in into element 0; its valid bit becomes 1
//   load_en          load load_data / load_valid in parallel
//   clear_en         zero data and valid bits
//   p_out            all elements, element c at [c*DATA_WIDTH +: DATA_WIDTH]
//   valid_out        per-element valid bits
//   shift_out        element DEPTH-1 (the one discarded by the next shift)
module window_row_sr
  import parallel_window_sr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIXEL_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        shift_en,
  input  logic                        load_en,
  input  logic                        clear_en,
  input  logic [DATA_WIDTH-1:0]       shift_in,
  input  logic [DEPTH*DATA_WIDTH-1:0] load_data,
  input  logic [DEPTH-1:0]            load_valid,
  output logic [DEPTH*DATA_WIDTH-1:0] p_out,
  output logic [DEPTH-1:0]            valid_out,
  output logic [DATA_WIDTH-1:0]       shift_out
);

  logic [DEPTH*DATA_WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_en) begin
      data_d  = '0;
      valid_d = '0;
    end else if (load_en) begin
      data_d  = load_data;
      valid_d = load_valid;
    end else if (shift_en) begin
      data_d  = {data_q[(DEPTH-1)*DATA_WIDTH-1:0], shift_in};
      valid_d = {valid_q[DEPTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign p_out     = data_q;
  assign valid_out = valid_q;
  assign shift_out = data_q[(DEPTH-1)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/parallel_window_sr.sv
// parallel_window_sr
//   ROWS x DEPTH window of DATA_WIDTH-bit pixels for the convolution datapath.
//   Accepted ops shift a new column in, shift a new row up, clear, or do
//   nothing. A per-element valid map tracks the data; out_valid is raised only
//   for a complete window and held until consumed by out_ready.
// Ports:
//   clock, reset   rising-edge clock, async active-low reset
//   enable         global hold; 0 freezes state and forces in_ready low
//   in_valid/in_ready/op   op request handshake
//   col_in         new column, row r at [r*DATA_WIDTH +: DATA_WIDTH]
//   row_in         new row, column c at [c*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready    window handshake
//   p_out          element (r,c) at [(r*DEPTH+c)*DATA_WIDTH +: DATA_WIDTH]
//   shift_out      element (r,DEPTH-1) of each row
module parallel_window_sr
  import parallel_window_sr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PIXEL_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH,
  parameter int unsigned ROWS       = DEFAULT_ROWS
) (
  input  logic                                             clock,
  input  logic                                             reset,
  input  logic                                             enable,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [1:0]                                       op,
  input  logic [pixel_bus_width(ROWS, DATA_WIDTH)-1:0]     col_in,
  input  logic [pixel_bus_width(DEPTH, DATA_WIDTH)-1:0]    row_in,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [pixel_bus_width(ROWS*DEPTH, DATA_WIDTH)-1:0] p_out,
  output logic [pixel_bus_width(ROWS, DATA_WIDTH)-1:0]     shift_out
);

  localparam int unsigned ROW_W = DEPTH * DATA_WIDTH;

  logic        pending_q, pending_d;
  logic        accept;
  logic        out_hs;
  logic        shift_col_en, shift_row_en, clear_en;
  op_e         op_cur;

  logic [ROW_W-1:0] row_data  [ROWS];
  logic [DEPTH-1:0] row_valid [ROWS];

  // Valid map as it would look after each kind of shift.
  logic [ROWS*DEPTH-1:0] col_map_next;
  logic [ROWS*DEPTH-1:0] row_map_next;

  assign op_cur       = op_e'(op);
  assign in_ready     = enable & (~pending_q | out_ready);
  assign accept       = in_valid & in_ready;
  assign out_hs       = enable & pending_q & out_ready;
  assign shift_col_en = accept & (op_cur == OP_SHIFT_COL);
  assign shift_row_en = accept & (op_cur == OP_SHIFT_ROW);
  assign clear_en     = accept & (op_cur == OP_CLEAR);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic [ROW_W-1:0] load_data;
    logic [DEPTH-1:0] load_valid;

    // Row 0 takes the new row; every other row takes the row beneath it.
    if (r == 0) begin : g_first
      assign load_data  = row_in;
      assign load_valid = '1;
    end else begin : g_up
      assign load_data  = row_data[r-1];
      assign load_valid = row_valid[r-1];
    end

    window_row_sr #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
    ) u_row (
      .clock      (clock),
      .reset      (reset),
      .shift_en   (shift_col_en),
      .load_en    (shift_row_en),
      .clear_en   (clear_en),
      .shift_in   (col_in[r*DATA_WIDTH +: DATA_WIDTH]),
      .load_data  (load_data),
      .load_valid (load_valid),
      .p_out      (row_data[r]),
      .valid_out  (row_valid[r]),
      .shift_out  (shift_out[r*DATA_WIDTH +: DATA_WIDTH])
    );

    assign p_out[r*ROW_W +: ROW_W]         = row_data[r];
    assign col_map_next[r*DEPTH +: DEPTH]  = {row_valid[r][DEPTH-2:0], 1'b1};
    assign row_map_next[r*DEPTH +: DEPTH]  = load_valid;
  end

  // An accepted shift overrides the consume-clear, so a window consumed in
  // the same cycle as a shift is immediately replaced by the new one.
  always_comb begin
    pending_d = pending_q;
    if (out_hs) begin
      pending_d = 1'b0;
    end
    if (accept) begin
      unique case (op_cur)
        OP_SHIFT_COL: pending_d = &col_map_next;
        OP_SHIFT_ROW: pending_d = &row_map_next;
        OP_CLEAR:     pending_d = 1'b0;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign out_valid = pending_q;

endmodule
